// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - program-load handshake between a loader (master) and the sequencer (slave).
interface alu_op_sequencer_if;
  logic       load_valid;
  logic [3:0] load_op;
  logic [3:0] load_data;
  logic       load_ready;

  modport master (output load_valid, output load_op, output load_data, input load_ready);
  modport slave  (input load_valid, input load_op, input load_data, output load_ready);
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - steps a small program through an external ALU, two cycles per entry.
module alu_op_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    ld,
  input  logic                 clear,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           acc_out,
  output logic [3:0]           alu_op,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  input  logic [3:0]           alu_result
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   pc_q;
  logic [3:0]      acc_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0]      alu_op_q;
  logic [3:0]      alu_a_q;
  logic [3:0]      alu_b_q;
  logic [7:0]      prog_q [DEPTH];

  logic            load_ready_w;
  logic            load_fire;
  logic [CW-1:0]   count_d;
  logic [7:0]      entry0;
  logic [PW-1:0]   pc_inc;
  logic [7:0]      next_entry;
  logic            last_entry;
  logic [3:0]      acc_d;

  assign load_ready_w = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  // clear wins over a same-cycle load, so a cleared cycle never writes memory
  assign load_fire    = ld.load_valid && load_ready_w && !clear;
  assign count_d      = load_fire ? count_q + CW'(1) : count_q;
  // a load accepted on the start edge into an empty program must be visible as entry 0
  assign entry0       = (load_fire && count_q == '0) ? {ld.load_op, ld.load_data} : prog_q[0];
  assign pc_inc       = pc_q + PW'(1);
  assign next_entry   = prog_q[pc_inc];
  assign last_entry   = (CW'(pc_q) == count_q - CW'(1));

  always_comb begin
    acc_d = acc_q;
    if (alu_op_q < 4'd8)
      acc_d = alu_result;
    else if (alu_op_q == 4'd8)
      acc_d = alu_b_q;
  end

  always_ff @(posedge clk) begin
    if (load_fire)
      prog_q[count_q[PW-1:0]] <= {ld.load_op, ld.load_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      pc_q     <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (clear) begin
            count_q <= '0;
            acc_q   <= '0;
          end else begin
            count_q <= count_d;
            if (start) begin
              if (count_d != '0) begin
                state_q  <= S_ISSUE;
                pc_q     <= '0;
                busy_q   <= 1'b1;
                alu_op_q <= entry0[7:4];
                alu_a_q  <= acc_q;
                alu_b_q  <= entry0[3:0];
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          acc_q <= acc_d;
          if (last_entry) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
          end else begin
            state_q  <= S_ISSUE;
            pc_q     <= pc_inc;
            alu_op_q <= next_entry[7:4];
            alu_a_q  <= acc_d;
            alu_b_q  <= next_entry[3:0];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ld.load_ready = load_ready_w;
  assign busy          = busy_q;
  assign done          = done_q;
  assign acc_out       = acc_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed scoreboard bench for alu_op_sequencer.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [3:0] acc_out, alu_op, alu_a, alu_b, alu_result;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit         is_done;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] acc;
    int         cycles;
  } exp_t;

  exp_t sbq[$];

  alu_op_sequencer_if lif ();

  alu_op_sequencer #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (lif),
    .clear      (clear),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .acc_out    (acc_out),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // external ALU; unused opcodes return a value the sequencer must ignore
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a ^ 4'hF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.is_done = 1'b0; e.op = op; e.a = a; e.b = b; e.acc = '0; e.cycles = 0;
    sbq.push_back(e);
  endtask

  task automatic push_done(input logic [3:0] acc, input int cycles);
    exp_t e;
    e.is_done = 1'b1; e.op = '0; e.a = '0; e.b = '0; e.acc = acc; e.cycles = cycles;
    sbq.push_back(e);
  endtask

  task automatic load(input logic [3:0] op, input logic [3:0] data);
    lif.load_valid = 1'b1;
    lif.load_op    = op;
    lif.load_data  = data;
    @(negedge clk);
    lif.load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++)
      @(negedge clk);
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
  endtask

  // monitor: ISSUE cycles pop an operand set, CAPTURE cycles recheck it, done pops the result
  initial begin
    int   bcnt;
    exp_t cur;
    exp_t e;
    bcnt = 0;
    cur = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
        continue;
      end
      if (busy === 1'b1) begin
        bcnt++;
        if (bcnt % 2 == 1) begin
          if (sbq.size() == 0 || sbq[0].is_done) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_issue: got op=%0d a=%0d b=%0d expected no issue", alu_op, alu_a, alu_b);
          end else begin
            cur = sbq.pop_front();
            chk("issue_op", alu_op, cur.op);
            chk("issue_a", alu_a, cur.a);
            chk("issue_b", alu_b, cur.b);
          end
        end else begin
          chk("capture_op", alu_op, cur.op);
          chk("capture_a", alu_a, cur.a);
          chk("capture_b", alu_b, cur.b);
        end
      end
      if (done === 1'b1) begin
        if (sbq.size() == 0 || !sbq[0].is_done) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          e = sbq.pop_front();
          chk("done_acc", acc_out, e.acc);
          chk("done_busy_cycles", bcnt, e.cycles);
          chk("done_alu_op_zero", alu_op, 0);
          chk("done_busy_low", busy, 0);
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] t6_op [8] = '{4'd8, 4'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] t6_b  [8] = '{4'd1, 4'd1, 4'd7, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    logic [3:0] t6_a  [8] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

    lif.load_valid = 1'b0;
    lif.load_op    = '0;
    lif.load_data  = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_load_ready", lif.load_ready, 1);

    // LOADI 3, ADD 5, SUB 1; clear/load during the run must be ignored
    load(4'd8, 4'd3);
    load(4'd0, 4'd5);
    load(4'd1, 4'd1);
    push_issue(4'd8, 4'd0, 4'd3);
    push_issue(4'd0, 4'd3, 4'd5);
    push_issue(4'd1, 4'd8, 4'd1);
    push_done(4'd7, 6);
    pulse_start();
    chk("run_load_ready_low", lif.load_ready, 0);
    clear = 1'b1;
    lif.load_valid = 1'b1; lif.load_op = 4'd8; lif.load_data = 4'hC;
    @(negedge clk);
    clear = 1'b0;
    lif.load_valid = 1'b0;
    wait_done(20);
    chk("t2_acc", acc_out, 7);
    chk("t2_load_ready", lif.load_ready, 1);

    // wrap and rerun without reload
    pulse_clear();
    chk("clear_acc", acc_out, 0);
    load(4'd8, 4'hF);
    load(4'd0, 4'd2);
    push_issue(4'd8, 4'd0, 4'hF);
    push_issue(4'd0, 4'hF, 4'd2);
    push_done(4'd1, 4);
    pulse_start();
    wait_done(20);
    push_issue(4'd8, 4'd1, 4'hF);
    push_issue(4'd0, 4'hF, 4'd2);
    push_done(4'd1, 4);
    pulse_start();
    wait_done(20);
    chk("t3_acc", acc_out, 1);

    // empty program: done on the very next cycle, no busy
    pulse_clear();
    push_done(4'd0, 0);
    pulse_start();
    chk("empty_done_next", done, 1);
    chk("empty_busy", busy, 0);
    wait_done(4);

    // load accepted on the start edge joins the run
    push_issue(4'd8, 4'd0, 4'd6);
    push_done(4'd6, 2);
    lif.load_valid = 1'b1; lif.load_op = 4'd8; lif.load_data = 4'd6;
    start = 1'b1;
    @(negedge clk);
    lif.load_valid = 1'b0;
    start = 1'b0;
    wait_done(10);
    chk("t5_acc", acc_out, 6);

    // fill to DEPTH, 9th load refused, includes a NOP entry
    pulse_clear();
    for (int k = 0; k < 8; k++) begin
      chk("fill_load_ready", lif.load_ready, 1);
      load(t6_op[k], t6_b[k]);
      push_issue(t6_op[k], t6_a[k], t6_b[k]);
    end
    chk("full_load_ready", lif.load_ready, 0);
    load(4'd0, 4'd5);
    push_done(4'd7, 16);
    pulse_start();
    wait_done(40);
    chk("t6_acc", acc_out, 7);

    // clear + load + start together: only the clear takes effect
    clear = 1'b1;
    start = 1'b1;
    lif.load_valid = 1'b1; lif.load_op = 4'd8; lif.load_data = 4'd4;
    @(negedge clk);
    clear = 1'b0; start = 1'b0; lif.load_valid = 1'b0;
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_acc", acc_out, 0);
    chk("t7_load_ready", lif.load_ready, 1);
    repeat (3) @(negedge clk);
    push_done(4'd0, 0);
    pulse_start();
    wait_done(4);

    // reset during CAPTURE of the second entry
    load(4'd8, 4'd2);
    load(4'd0, 4'd3);
    load(4'd0, 4'd1);
    push_issue(4'd8, 4'd0, 4'd2);
    push_issue(4'd0, 4'd2, 4'd3);
    push_issue(4'd0, 4'd5, 4'd1);
    push_done(4'd6, 6);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t8_busy_before", busy, 1);
    chk("t8_alu_a_before", alu_a, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_done", done, 0);
    chk("t8_acc", acc_out, 0);
    chk("t8_alu_op", alu_op, 0);
    chk("t8_alu_a", alu_a, 0);
    chk("t8_alu_b", alu_b, 0);
    sbq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t8_load_ready", lif.load_ready, 1);
    repeat (6) @(negedge clk);
    chk("t8_no_run", busy, 0);
    chk("final_sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning program-memory entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port load_valid  input  1  program-entry write request.
REQ-005 SHALL have port load_op  input  4  opcode of entry being loaded.
REQ-006 SHALL have port load_data  input  4  operand of entry being loaded.
REQ-007 SHALL have port load_ready  output  1  entry accepted when load_valid && load_ready.
REQ-008 SHALL have port clear  input  1  in IDLE: empty program, zero accumulator.
REQ-009 SHALL have port start  input  1  begin execution of loaded program.
REQ-010 SHALL have port busy  output  1  high while executing.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of program.
REQ-012 SHALL have port acc_out  output  4  current accumulator value.
REQ-013 SHALL have port alu_op  output  4  opcode driven to external ALU.
REQ-014 SHALL have port alu_a  output  4  ALU operand A (accumulator).
REQ-015 SHALL have port alu_b  output  4  ALU operand B (entry operand).
REQ-016 SHALL have port alu_result  input  4  combinational result from external ALU.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE, DONE.
REQ-018 SHALL assert load_ready only when state==IDLE and count<DEPTH; an accepted load writes {load_op,load_data} at index count, count+1.
REQ-019 SHALL ignore load_valid when count==DEPTH (no write, count unchanged).
REQ-020 SHALL, on clear in IDLE, set count=0 and acc=0; clear beats a same-cycle load and start; clear outside IDLE ignored.
REQ-021 SHALL, on start in IDLE with a same-cycle accepted load, include that entry in the run.
REQ-022 SHALL transition IDLE->ISSUE on start with count>0 (pc=0); IDLE->DONE on start with count==0.
REQ-023 SHALL, in ISSUE and CAPTURE, hold alu_op=prog[pc].op, alu_a=acc, alu_b=prog[pc].data, all registered (stable both cycles).
REQ-024 SHALL transition ISSUE->CAPTURE unconditionally.
REQ-025 SHALL, at CAPTURE end, update acc: ops 0-7 acc<=alu_result; op 8 (LOADI) acc<=operand; ops 9-15 no change (NOP).
REQ-026 SHALL, at CAPTURE end, go to DONE if pc==count-1, else pc+1 and go to ISSUE.
REQ-027 SHALL take exactly 2 cycles per entry; N entries: busy high 2N cycles, done on cycle 2N+1 after start edge.
REQ-028 SHALL drive busy=1 in ISSUE/CAPTURE only; done=1 in DONE only; DONE->IDLE unconditionally.
REQ-029 SHALL ignore start, load_valid, clear while not IDLE.
REQ-030 SHALL apply no width growth: accumulator 4 bits, wrap from ALU is accepted as-is.
REQ-031 SHALL retain program and count after DONE, so a new start reruns it on the current acc.
REQ-032 SHALL drive alu_op/alu_a/alu_b to 0 in IDLE and DONE.

Reset
REQ-033 SHALL, on rst_n low, immediately force state=IDLE, count=0, pc=0, acc=0, busy=0, done=0, acc_out=0, alu_op/alu_a/alu_b=0, load_ready=1 after release.
REQ-034 SHALL abort any run on reset mid-operation with no done pulse; program memory need not be reset.

Verification
REQ-035 SHALL cover: load LOADI 3, ADD 5, SUB 1; start -> busy 6 cycles, alu_op 0 with a=3,b=5 then 1 with a=8,b=1, acc_out=7, single done pulse.
REQ-036 SHALL cover: LOADI F, ADD 2 -> acc_out=1 (wrap); rerun without reload -> acc_out=1 after LOADI F resets it.
REQ-037 SHALL cover: load 9 entries with DEPTH=8 -> 9th not accepted, load_ready=0, count=8, run busy 16 cycles.
REQ-038 SHALL cover: start with empty program -> busy never high, done pulse next cycle, acc unchanged.
REQ-039 SHALL cover: rst_n low during CAPTURE of 2nd entry -> all outputs 0 same cycle, no done, load_ready=1 after release.
REQ-040 SHALL cover: clear+load_valid+start same cycle in IDLE -> count=0, acc=0, nothing loaded, no run.
